// File: rtl/ram_sp_arbiter2_pkg.sv
// Shared definitions for the two-port single-port-RAM access controller.
// State encodings are reused by sibling RAM controllers.
package ram_sp_arbiter2_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/ram_sp_arbiter2_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2 (
    input  logic [1:0] req_eligible,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req_eligible;
        if (&req_eligible)
            grant_id = ~last_grant;
        else
            grant_id = req_eligible[1];
    end

endmodule

// File: rtl/ram_sp_arbiter2.sv
// Round-robin access controller serialising two req/ack clients onto one
// single-port synchronous RAM; sole owner of the RAM pins and data bus.
module ram_sp_arbiter2
    import ram_sp_arbiter2_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_address,
    inout  wire  [DW-1:0] ram_data,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_oe,
    output logic          busy
);

    state_t              state, state_nxt;
    logic                last_grant;
    logic                lat_port;
    logic                lat_wr;
    logic [AW-1:0]       lat_addr;
    logic [DW-1:0]       lat_wdata;
    logic [1:0]          ack_q;
    logic [1:0][DW-1:0]  rdata_q;
    logic [1:0]          req_elig;
    logic                grant_valid;
    logic                grant_id;

    // A port being acked this cycle is dropping its request, so ignore it.
    assign req_elig = {req1, req0} & ~ack_q;

    rr_arbiter2 u_arb (
        .req_eligible (req_elig),
        .last_grant   (last_grant),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (grant_valid) state_nxt = ST_ACCESS;
            ST_ACCESS:  state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
        end else begin
            ack_q <= '0;
            if (state == ST_IDLE && grant_valid) begin
                last_grant <= grant_id;
                lat_port   <= grant_id;
                lat_wr     <= grant_id ? wr1    : wr0;
                lat_addr   <= grant_id ? addr1  : addr0;
                lat_wdata  <= grant_id ? wdata1 : wdata0;
            end
            // RAM has been driving the bus since the edge that ended ACCESS.
            if (state == ST_CAPTURE) begin
                ack_q[lat_port] <= 1'b1;
                if (!lat_wr)
                    rdata_q[lat_port] <= ram_data;
            end
        end
    end

    // RAM pins are decoded purely from registered state and latches.
    always_comb begin
        ram_cs      = (state != ST_IDLE);
        ram_we      = (state == ST_ACCESS) && lat_wr;
        ram_oe      = ((state == ST_ACCESS) && !lat_wr) || (state == ST_CAPTURE);
        ram_address = (state == ST_IDLE) ? '0 : lat_addr;
    end

    assign ram_data = (ram_we && !ram_oe) ? lat_wdata : 'z;

    assign ack0   = ack_q[0];
    assign ack1   = ack_q[1];
    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];
    assign busy   = (state != ST_IDLE);

endmodule
